// File: rtl/dram_credit_buffer.sv
// dram_credit_buffer: credit-limited request bridge between the AXI request
// arbiter and the sim_dram model. Reads and writes are bounded by credit
// counters so the DRAM model's response ports never see back-pressure; read
// data waits in a local FIFO and write completions in a pending counter.
//
// Optional build macro: DRAM_CREDIT_PERF_EN adds three 32-bit saturating
// stall/hold counters (perf_rd_stall_o, perf_wr_stall_o, perf_rsp_hold_o).
module dram_credit_buffer #(
  parameter int unsigned DataWidth        = 512,
  parameter int unsigned AddrWidth        = 32,
  parameter int unsigned RdBufDepth       = 8,
  parameter int unsigned WrMaxOutstanding = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic                   dram_req_valid_o,
  input  logic                   dram_req_ready_i,
  output logic                   dram_we_o,
  output logic [AddrWidth-1:0]   dram_addr_o,
  output logic [DataWidth-1:0]   dram_wdata_o,
  output logic [DataWidth/8-1:0] dram_wstrb_o,
  input  logic                   dram_rsp_valid_i,
  output logic                   dram_rsp_ready_o,
  input  logic [DataWidth-1:0]   dram_rdata_i,
  input  logic                   dram_b_valid_i,
  output logic                   dram_b_ready_o
`ifdef DRAM_CREDIT_PERF_EN
  ,
  output logic [31:0]            perf_rd_stall_o,
  output logic [31:0]            perf_wr_stall_o,
  output logic [31:0]            perf_rsp_hold_o
`endif
);

  localparam int unsigned RdCntW = $clog2(RdBufDepth + 1);
  localparam int unsigned WrCntW = $clog2(WrMaxOutstanding + 1);
  localparam int unsigned PtrW   = (RdBufDepth > 1) ? $clog2(RdBufDepth) : 1;

  localparam logic [RdCntW-1:0] RdMax   = RdCntW'(RdBufDepth);
  localparam logic [RdCntW-1:0] RdOne   = RdCntW'(1);
  localparam logic [WrCntW-1:0] WrMax   = WrCntW'(WrMaxOutstanding);
  localparam logic [WrCntW-1:0] WrOne   = WrCntW'(1);
  localparam logic [PtrW-1:0]   PtrLast = PtrW'(RdBufDepth - 1);
  localparam logic [PtrW-1:0]   PtrOne  = PtrW'(1);

  logic [RdCntW-1:0]    rd_out;
  logic [RdCntW-1:0]    fifo_cnt;
  logic [WrCntW-1:0]    wr_out;
  logic [WrCntW-1:0]    b_pend;
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [DataWidth-1:0] rd_mem [RdBufDepth];

  logic credit_ok;
  logic issue;
  logic rd_issue;
  logic wr_issue;
  logic rd_push;
  logic rd_pop;
  logic b_pop;

  // Credit check for the request type currently presented upstream.
  always_comb begin
    credit_ok = we_i ? (wr_out < WrMax) : (rd_out < RdMax);
  end

  // Zero-latency request path; valid never looks at the DRAM ready.
  assign dram_req_valid_o = req_valid_i & credit_ok;
  assign req_ready_o      = dram_req_ready_i & credit_ok;
  assign dram_we_o        = we_i;
  assign dram_addr_o      = addr_i;
  assign dram_wdata_o     = wdata_i;
  assign dram_wstrb_o     = wstrb_i;
  assign dram_rsp_ready_o = 1'b1;
  assign dram_b_ready_o   = 1'b1;

  assign issue    = req_valid_i & req_ready_o;
  assign rd_issue = issue & ~we_i;
  assign wr_issue = issue & we_i;
  assign rd_push  = dram_rsp_valid_i;
  assign rd_pop   = rsp_valid_o & rsp_ready_i;
  assign b_pop    = b_valid_o & b_ready_i;

  assign rsp_valid_o = (fifo_cnt != '0);
  assign b_valid_o   = (b_pend != '0);
  // Storage is not reset, so mask the head while empty to keep rdata_o at 0.
  assign rdata_o     = rsp_valid_o ? rd_mem[rd_ptr] : '0;

  // Read credits: held from issue until the data leaves upstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_out <= '0;
    end else if (rd_issue && !rd_pop) begin
      rd_out <= rd_out + RdOne;
    end else if (!rd_issue && rd_pop) begin
      rd_out <= rd_out - RdOne;
    end
  end

  // Write credits: held from issue until the upstream B handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_out <= '0;
    end else if (wr_issue && !b_pop) begin
      wr_out <= wr_out + WrOne;
    end else if (!wr_issue && b_pop) begin
      wr_out <= wr_out - WrOne;
    end
  end

  // Pending write acknowledges absorbed from the DRAM model.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_pend <= '0;
    end else if (dram_b_valid_i && !b_pop) begin
      b_pend <= b_pend + WrOne;
    end else if (!dram_b_valid_i && b_pop) begin
      b_pend <= b_pend - WrOne;
    end
  end

  // Read FIFO occupancy and pointers; wrap explicitly for any depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (rd_push && !rd_pop) begin
        fifo_cnt <= fifo_cnt + RdOne;
      end else if (!rd_push && rd_pop) begin
        fifo_cnt <= fifo_cnt - RdOne;
      end
      if (rd_push) begin
        wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + PtrOne;
      end
      if (rd_pop) begin
        rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + PtrOne;
      end
    end
  end

  // Read data storage; written on every DRAM response.
  always_ff @(posedge clk_i) begin
    if (rd_push) begin
      rd_mem[wr_ptr] <= dram_rdata_i;
    end
  end

`ifdef DRAM_CREDIT_PERF_EN
  // Saturating performance counters for credit stalls and upstream holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_rd_stall_o <= '0;
      perf_wr_stall_o <= '0;
      perf_rsp_hold_o <= '0;
    end else begin
      if (req_valid_i && !we_i && !credit_ok && (perf_rd_stall_o != '1)) begin
        perf_rd_stall_o <= perf_rd_stall_o + 32'd1;
      end
      if (req_valid_i && we_i && !credit_ok && (perf_wr_stall_o != '1)) begin
        perf_wr_stall_o <= perf_wr_stall_o + 32'd1;
      end
      if (rsp_valid_o && !rsp_ready_i && (perf_rsp_hold_o != '1)) begin
        perf_rsp_hold_o <= perf_rsp_hold_o + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Protocol checks: these can only fire if the environment breaks the credit contract.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(dram_b_valid_i && (b_pend == wr_out)))
        else $error("dram_credit_buffer: write completion with no outstanding write");
      assert (!(rd_push && (fifo_cnt == RdMax)))
        else $error("dram_credit_buffer: read response while FIFO full");
      assert (!(rd_pop && (rd_out == '0)))
        else $error("dram_credit_buffer: rd_out underflow");
      assert (!(b_pop && (wr_out == '0)))
        else $error("dram_credit_buffer: wr_out underflow");
      assert (!(b_pop && (b_pend == '0)))
        else $error("dram_credit_buffer: b_pend underflow");
      assert (!(rd_pop && (fifo_cnt == '0)))
        else $error("dram_credit_buffer: FIFO underflow");
    end
  end
`endif

endmodule

// File: tb/tb_dram_credit_buffer.sv
// Directed bench for dram_credit_buffer: a combinational vector table for the
// request path, then hand-written sequences for credit limits, FIFO ordering,
// write acknowledges and mid-operation reset.
module tb_dram_credit_buffer;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [SW-1:0] wstrb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rdata_o;
  logic          b_valid_o;
  logic          b_ready_i;
  logic          dram_req_valid_o;
  logic          dram_req_ready_i;
  logic          dram_we_o;
  logic [AW-1:0] dram_addr_o;
  logic [DW-1:0] dram_wdata_o;
  logic [SW-1:0] dram_wstrb_o;
  logic          dram_rsp_valid_i;
  logic          dram_rsp_ready_o;
  logic [DW-1:0] dram_rdata_i;
  logic          dram_b_valid_i;
  logic          dram_b_ready_o;

  dram_credit_buffer #(
    .DataWidth(DW), .AddrWidth(AW), .RdBufDepth(8), .WrMaxOutstanding(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rdata_o(rdata_o),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .dram_req_valid_o(dram_req_valid_o), .dram_req_ready_i(dram_req_ready_i),
    .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_wstrb_o(dram_wstrb_o),
    .dram_rsp_valid_i(dram_rsp_valid_i), .dram_rsp_ready_o(dram_rsp_ready_o),
    .dram_rdata_i(dram_rdata_i),
    .dram_b_valid_i(dram_b_valid_i), .dram_b_ready_o(dram_b_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          rv;
    logic          we;
    logic          dr;
    logic [AW-1:0] addr;
    logic          exp_dv;
    logic          exp_rr;
  } vec_t;

  vec_t          vecs [7];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] next_addr = '0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] rsp_pend [$];
  int            b_due = 0;
  bit            auto_rsp = 1'b1;
  bit            auto_b = 1'b1;
  int            rd_pops = 0;
  int            b_pops = 0;
  int            acc;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16{32'hA5A5A5A5 ^ a}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records handshakes in the current cycle, advances one clock, then plays
  // the DRAM model: one queued read response and one write completion per cycle.
  task automatic tick();
    if (req_valid_i && req_ready_o) begin
      if (we_i) begin
        b_due++;
      end else begin
        exp_q.push_back(addr_i);
        rsp_pend.push_back(addr_i);
      end
      next_addr++;
    end
    if (rsp_valid_o && rsp_ready_i) begin
      rd_pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got pop of %0h expected no data", rdata_o);
      end else begin
        chk_w("rd_data_order", rdata_o, pat(exp_q.pop_front()));
      end
    end
    if (b_valid_o && b_ready_i) b_pops++;
    @(posedge clk_i);
    #1;
    dram_rsp_valid_i = 1'b0;
    if (auto_rsp && rsp_pend.size() > 0) begin
      dram_rsp_valid_i = 1'b1;
      dram_rdata_i     = pat(rsp_pend.pop_front());
    end
    dram_b_valid_i = 1'b0;
    if (auto_b && b_due > 0) begin
      b_due--;
      dram_b_valid_i = 1'b1;
    end
  endtask

  task automatic present(input logic we);
    req_valid_i = 1'b1;
    we_i        = we;
    addr_i      = next_addr;
    wdata_i     = pat(next_addr);
    wstrb_i     = {2{next_addr}};
  endtask

  task automatic drain_rd(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && rsp_pend.size() == 0 && !rsp_valid_o && !dram_rsp_valid_i) break;
      tick();
    end
  endtask

  task automatic drain_b(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (b_due == 0 && !b_valid_o && !dram_b_valid_i) break;
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hDEAD_0040, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hBEEF_0050, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};

    rst_ni           = 1'b0;
    req_valid_i      = 1'b0;
    we_i             = 1'b0;
    addr_i           = '0;
    wdata_i          = '0;
    wstrb_i          = '0;
    rsp_ready_i      = 1'b0;
    b_ready_i        = 1'b0;
    dram_req_ready_i = 1'b0;
    dram_rsp_valid_i = 1'b0;
    dram_rdata_i     = '0;
    dram_b_valid_i   = 1'b0;

    #3;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk_w("rst_rdata", rdata_o, '0);
    chk("rst_dram_req_valid", dram_req_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_dram_rsp_ready", dram_rsp_ready_o, 1);
    chk("rst_dram_b_ready", dram_b_ready_o, 1);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();

    // Combinational request path with all credits free; no clock edge here.
    for (int i = 0; i < 7; i++) begin
      req_valid_i      = vecs[i].rv;
      we_i             = vecs[i].we;
      dram_req_ready_i = vecs[i].dr;
      addr_i           = vecs[i].addr;
      wdata_i          = pat(vecs[i].addr);
      wstrb_i          = {2{vecs[i].addr}};
      #1;
      chk("vec_dram_req_valid", dram_req_valid_o, vecs[i].exp_dv);
      chk("vec_req_ready", req_ready_o, vecs[i].exp_rr);
      chk("vec_dram_we", dram_we_o, vecs[i].we);
      chk("vec_dram_addr", dram_addr_o, vecs[i].addr);
      chk_w("vec_dram_wdata", dram_wdata_o, pat(vecs[i].addr));
      chk_w("vec_dram_wstrb", DW'(dram_wstrb_o), DW'({2{vecs[i].addr}}));
    end
    req_valid_i      = 1'b0;
    dram_req_ready_i = 1'b1;
    tick();

    // Single read; DRAM answers three cycles after issue; one-cycle visibility.
    auto_rsp    = 1'b0;
    rsp_ready_i = 1'b1;
    present(1'b0);
    #1 chk("t1_accept", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    dram_rsp_valid_i = 1'b1;
    dram_rdata_i     = pat(rsp_pend.pop_front());
    #1 chk("t1_no_fallthrough", rsp_valid_o, 0);
    tick();
    #1 chk("t1_rsp_valid", rsp_valid_o, 1);
    chk_w("t1_rdata", rdata_o, {16{32'hA5A5A5A5}});
    tick();
    #1 chk("t1_rsp_gone", rsp_valid_o, 0);
    auto_rsp = 1'b1;

    // Ten reads with upstream stalled: only eight credits.
    rsp_ready_i = 1'b0;
    rd_pops     = 0;
    for (int i = 0; i < 8; i++) begin
      present(1'b0);
      #1 chk("t2_accept", req_ready_o, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      present(1'b0);
      #1 chk("t2_stall_ready", req_ready_o, 0);
      chk("t2_stall_dram_valid", dram_req_valid_o, 0);
      tick();
    end
    we_i = 1'b1;
    #1 chk("t2_write_credit_free", req_ready_o, 1);
    we_i = 1'b0;
    rsp_ready_i = 1'b1;
    #1 chk("t2_pop_cycle_ready", req_ready_o, 0);
    chk("t2_pop_cycle_valid", rsp_valid_o, 1);
    tick();
    present(1'b0);
    #1 chk("t2_9th_issue", req_ready_o, 1);
    tick();
    present(1'b0);
    #1 chk("t2_10th_issue", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    drain_rd(40);
    chk("t2_pops", rd_pops, 10);
    chk("t2_empty", rsp_valid_o, 0);

    // FIFO at three, push and pop in the same cycle.
    rsp_ready_i = 1'b0;
    rd_pops     = 0;
    for (int i = 0; i < 3; i++) begin
      present(1'b0);
      #1 chk("t3_accept", req_ready_o, 1);
      tick();
    end
    req_valid_i = 1'b0;
    tick();
    tick();
    chk("t3_filled", rsp_valid_o, 1);
    present(1'b0);
    tick();
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    drain_rd(20);
    chk("t3_pops", rd_pops, 4);
    chk("t3_scoreboard_empty", exp_q.size(), 0);

    // Nine writes, acknowledges held upstream.
    b_ready_i = 1'b0;
    b_pops    = 0;
    for (int i = 0; i < 8; i++) begin
      present(1'b1);
      #1 chk("t4_accept", req_ready_o, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      present(1'b1);
      #1 chk("t4_stall_ready", req_ready_o, 0);
      chk("t4_stall_dram_valid", dram_req_valid_o, 0);
      tick();
    end
    chk("t4_b_valid", b_valid_o, 1);
    b_ready_i = 1'b1;
    #1 chk("t4_b_pop_cycle_ready", req_ready_o, 0);
    tick();
    b_ready_i = 1'b0;
    #1 chk("t4_9th_issue", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    tick();
    b_ready_i = 1'b1;
    drain_b(30);
    chk("t4_b_pops", b_pops, 9);
    chk("t4_b_empty", b_valid_o, 0);
    b_ready_i = 1'b0;

    // wr_out = 5, write issue together with a B handshake.
    for (int i = 0; i < 5; i++) begin
      present(1'b1);
      #1 chk("t5_accept", req_ready_o, 1);
      tick();
    end
    req_valid_i = 1'b0;
    tick();
    present(1'b1);
    b_ready_i = 1'b1;
    #1 chk("t5_both_ready", req_ready_o, 1);
    chk("t5_both_bvalid", b_valid_o, 1);
    tick();
    b_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      present(1'b1);
      #1;
      if (req_ready_o) acc++;
      tick();
    end
    req_valid_i = 1'b0;
    chk("t5_credits_left", acc, 3);
    b_pops    = 0;
    b_ready_i = 1'b1;
    drain_b(30);
    chk("t5_b_pops", b_pops, 8);
    b_ready_i = 1'b0;

    // Reset with 4 reads buffered and 2 acknowledges pending.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      present(1'b1);
      tick();
    end
    req_valid_i = 1'b0;
    tick();
    tick();
    chk("t6_pre_rsp_valid", rsp_valid_o, 1);
    chk("t6_pre_b_valid", b_valid_o, 1);
    rst_ni = 1'b0;
    #1 chk("t6_rst_rsp_valid", rsp_valid_o, 0);
    chk("t6_rst_b_valid", b_valid_o, 0);
    chk_w("t6_rst_rdata", rdata_o, '0);
    exp_q.delete();
    rsp_pend.delete();
    b_due = 0;
    tick();
    rst_ni = 1'b1;
    tick();
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      present(1'b0);
      #1;
      if (req_ready_o) acc++;
      tick();
    end
    req_valid_i = 1'b0;
    chk("t6_rd_credits", acc, 8);
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      present(1'b1);
      #1;
      if (req_ready_o) acc++;
      tick();
    end
    req_valid_i = 1'b0;
    chk("t6_wr_credits", acc, 8);
    rd_pops     = 0;
    rsp_ready_i = 1'b1;
    b_ready_i   = 1'b1;
    drain_rd(40);
    drain_b(40);
    chk("t6_rd_pops", rd_pops, 8);
    chk("t6_rsp_empty", rsp_valid_o, 0);
    chk("t6_b_empty", b_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
